ddr_request_arbiter: RTL and testbench

//   Shares the single DDR SDRAM controller command/data port between two requesters.

---
 rtl/ddr_request_arbiter.sv | 151 +++++++++++++++
 tb/tb_ddr_request_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_request_arbiter.sv
// rtl/ddr_request_arbiter.sv - two-requester arbiter for the shared DDR command/data port
// Optional ARB_AGING_EN: life-engine wait counter promotes it over display after MAX_WAIT cycles.
`timescale 1ns/1ps
module ddr_request_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int MAX_WAIT  = 64
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic              dispGnt,
  output logic              dispRdValid,
  output logic [DATA_W-1:0] dispRdData,
  output logic              dispDone,
  input  logic              lifeReq,
  input  logic              lifeWe,
  input  logic [ADDR_W-1:0] lifeAddr,
  input  logic [DATA_W-1:0] lifeWrData,
  output logic              lifeGnt,
  output logic              lifeWrAck,
  output logic              lifeRdValid,
  output logic [DATA_W-1:0] lifeRdData,
  output logic              lifeDone,
  output logic              memCmdValid,
  input  logic              memCmdReady,
  output logic              memCmdWe,
  output logic [ADDR_W-1:0] memCmdAddr,
  output logic [DATA_W-1:0] memWrData,
  input  logic              memWrReady,
  input  logic              memRdValid,
  input  logic [DATA_W-1:0] memRdData,
  output logic              protoErr
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_beat;
  logic              r_gnt_disp;
  logic              r_gnt_life;
  logic              r_proto_err;

  logic w_rd_phase;
  logic w_wr_phase;
  logic w_beat;
  logic w_last;
  logic w_any_req;
  logic w_pick_life;
  logic w_aged;

  assign w_rd_phase  = (r_state == S_DATA) && !r_we;
  assign w_wr_phase  = (r_state == S_DATA) && r_we;
  assign w_beat      = (w_rd_phase && memRdValid) || (w_wr_phase && memWrReady);
  assign w_last      = w_beat && (r_beat == CNT_W'(BURST_LEN - 1));
  assign w_any_req   = dispReq || lifeReq;
  assign w_pick_life = lifeReq && (!dispReq || w_aged);

`ifdef ARB_AGING_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] r_wait;

  assign w_aged = (r_wait == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wait <= '0;
    end else if (r_gnt_life) begin
      r_wait <= '0;
    end else if (lifeReq && !w_aged) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end
`else
  // Strict display priority: MAX_WAIT only matters in the aging build.
  assign w_aged = (MAX_WAIT < 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: if (memCmdReady) w_state_nxt = S_DATA;
      S_DATA:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_beat      <= '0;
      r_gnt_disp  <= 1'b0;
      r_gnt_life  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_disp <= 1'b0;
      r_gnt_life <= 1'b0;
      if ((r_state == S_IDLE) && w_any_req) begin
        r_owner    <= w_pick_life;
        r_we       <= w_pick_life && lifeWe;
        r_addr     <= w_pick_life ? lifeAddr : dispAddr;
        r_gnt_disp <= !w_pick_life;
        r_gnt_life <= w_pick_life;
      end
      if (r_state != S_DATA) begin
        r_beat <= '0;
      end else if (w_beat) begin
        r_beat <= r_beat + CNT_W'(1);
      end
      // Strobes that do not match the current burst direction are never counted.
      if ((memRdValid && !w_rd_phase) || (memWrReady && !w_wr_phase)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign dispGnt     = r_gnt_disp;
  assign lifeGnt     = r_gnt_life;
  assign dispRdValid = w_rd_phase && !r_owner && memRdValid;
  assign lifeRdValid = w_rd_phase && r_owner && memRdValid;
  assign dispRdData  = dispRdValid ? memRdData : '0;
  assign lifeRdData  = lifeRdValid ? memRdData : '0;
  assign lifeWrAck   = w_wr_phase && memWrReady;
  assign memWrData   = w_wr_phase ? lifeWrData : '0;
  assign dispDone    = (r_state == S_DONE) && !r_owner;
  assign lifeDone    = (r_state == S_DONE) && r_owner;
  assign memCmdValid = (r_state == S_ISSUE);
  assign memCmdWe    = memCmdValid && r_we;
  assign memCmdAddr  = memCmdValid ? r_addr : '0;
  assign protoErr    = r_proto_err;

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// tb/tb_ddr_request_arbiter.sv - directed bench with a transaction-level reference model
`timescale 1ns/1ps
module tb_ddr_request_arbiter;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int BL = 8;
  localparam int MW = 64;
`ifdef ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN;
  logic dispReq, dispGnt, dispRdValid, dispDone;
  logic [AW-1:0] dispAddr;
  logic [DW-1:0] dispRdData;
  logic lifeReq, lifeWe, lifeGnt, lifeWrAck, lifeRdValid, lifeDone;
  logic [AW-1:0] lifeAddr;
  logic [DW-1:0] lifeWrData, lifeRdData;
  logic memCmdValid, memCmdReady, memCmdWe, memWrReady, memRdValid, protoErr;
  logic [AW-1:0] memCmdAddr;
  logic [DW-1:0] memWrData, memRdData;

  always #5 clk = ~clk;

  ddr_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .MAX_WAIT(MW)) dut (
    .clk(clk), .rstN(rstN),
    .dispReq(dispReq), .dispAddr(dispAddr), .dispGnt(dispGnt),
    .dispRdValid(dispRdValid), .dispRdData(dispRdData), .dispDone(dispDone),
    .lifeReq(lifeReq), .lifeWe(lifeWe), .lifeAddr(lifeAddr), .lifeWrData(lifeWrData),
    .lifeGnt(lifeGnt), .lifeWrAck(lifeWrAck), .lifeRdValid(lifeRdValid),
    .lifeRdData(lifeRdData), .lifeDone(lifeDone),
    .memCmdValid(memCmdValid), .memCmdReady(memCmdReady), .memCmdWe(memCmdWe),
    .memCmdAddr(memCmdAddr), .memWrData(memWrData), .memWrReady(memWrReady),
    .memRdValid(memRdValid), .memRdData(memRdData), .protoErr(protoErr)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a burst is "command pending", then "beats remaining", then a done cycle.
  bit m_cmd = 0, m_done = 0, m_owner = 0, m_we = 0, m_gd = 0, m_gl = 0, m_err = 0;
  bit m_old_gl, m_life_wins, m_rd_ok, m_wr_ok;
  int m_left = 0, m_wait = 0;
  logic [AW-1:0] m_addr = '0;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_cmd = 0; m_done = 0; m_owner = 0; m_we = 0; m_gd = 0; m_gl = 0;
      m_err = 0; m_left = 0; m_wait = 0; m_addr = '0;
    end else begin
      m_rd_ok = (m_left > 0) && !m_we;
      m_wr_ok = (m_left > 0) && m_we;
      if ((memRdValid && !m_rd_ok) || (memWrReady && !m_wr_ok)) m_err = 1;
      m_old_gl = m_gl;
      m_gd = 0;
      m_gl = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_left > 0) begin
        if (m_we ? memWrReady : memRdValid) begin
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end else if (m_cmd) begin
        if (memCmdReady) begin
          m_cmd = 0;
          m_left = BL;
        end
      end else if (dispReq || lifeReq) begin
        m_life_wins = lifeReq && (!dispReq || (AGING && m_wait >= MW));
        m_cmd = 1;
        m_owner = m_life_wins;
        m_we = m_life_wins && lifeWe;
        m_addr = m_life_wins ? lifeAddr : dispAddr;
        m_gd = !m_life_wins;
        m_gl = m_life_wins;
      end
      if (m_old_gl) m_wait = 0;
      else if (lifeReq && m_wait < MW) m_wait++;
    end
  end

  // Event log for the directed literal checks.
  logic [DW-1:0] disp_q[$];
  logic [DW-1:0] wr_q[$];
  int life_rd_n = 0, disp_gnt_n = 0, life_gnt_n = 0, disp_done_n = 0, life_done_n = 0;
  int disp_gnt_cyc = 0, life_gnt_cyc = 0, disp_done_cyc = 0, life_done_cyc = 0, last_ack_cyc = 0;
  logic [AW-1:0] last_addr = '0;
  logic last_we = 1'b0;
  bit e_rd, e_wr;

  always @(negedge clk) begin
    e_rd = (m_left > 0) && !m_we;
    e_wr = (m_left > 0) && m_we;
    chk("dispGnt", 64'(dispGnt), 64'(m_gd));
    chk("lifeGnt", 64'(lifeGnt), 64'(m_gl));
    chk("memCmdValid", 64'(memCmdValid), 64'(m_cmd));
    chk("memCmdWe", 64'(memCmdWe), 64'(m_cmd && m_we));
    chk("memCmdAddr", 64'(memCmdAddr), m_cmd ? 64'(m_addr) : 64'd0);
    chk("dispRdValid", 64'(dispRdValid), 64'(e_rd && !m_owner && memRdValid));
    chk("dispRdData", 64'(dispRdData), (e_rd && !m_owner && memRdValid) ? 64'(memRdData) : 64'd0);
    chk("lifeRdValid", 64'(lifeRdValid), 64'(e_rd && m_owner && memRdValid));
    chk("lifeRdData", 64'(lifeRdData), (e_rd && m_owner && memRdValid) ? 64'(memRdData) : 64'd0);
    chk("lifeWrAck", 64'(lifeWrAck), 64'(e_wr && memWrReady));
    chk("memWrData", 64'(memWrData), e_wr ? 64'(lifeWrData) : 64'd0);
    chk("dispDone", 64'(dispDone), 64'(m_done && !m_owner));
    chk("lifeDone", 64'(lifeDone), 64'(m_done && m_owner));
    chk("protoErr", 64'(protoErr), 64'(m_err));
    if (dispRdValid) disp_q.push_back(dispRdData);
    if (lifeRdValid) life_rd_n++;
    if (lifeWrAck) begin wr_q.push_back(memWrData); last_ack_cyc = cyc; end
    if (dispGnt) begin disp_gnt_n++; disp_gnt_cyc = cyc; end
    if (lifeGnt) begin life_gnt_n++; life_gnt_cyc = cyc; end
    if (dispDone) begin disp_done_n++; disp_done_cyc = cyc; end
    if (lifeDone) begin life_done_n++; life_done_cyc = cyc; end
    if (memCmdValid) begin last_addr = memCmdAddr; last_we = memCmdWe; end
  end

  // Controller and requester stimulus state.
  bit ctl_busy = 0, ctl_accepted = 0, ctl_acc_we = 0, ctl_we = 0, ctl_ph = 0, ctl_toggle = 0;
  bit hold_disp = 0, pulse_rd = 0;
  int ctl_wait = 0, ctl_delay = 0, ctl_beats = 0;
  int rd_base = 0, wr_base = 0;

  task automatic step();
    @(posedge clk);
    #1;
    memCmdReady = 0; memRdValid = 0; memWrReady = 0; memRdData = '0;
    if (ctl_accepted) begin
      ctl_busy = 1; ctl_beats = 0; ctl_we = ctl_acc_we; ctl_accepted = 0; ctl_ph = 0;
    end
    if (ctl_busy) begin
      if (ctl_beats < BL) begin
        if (ctl_we) lifeWrData = DW'(wr_base + ctl_beats);
        if (!ctl_toggle || !ctl_ph) begin
          if (ctl_we) memWrReady = 1;
          else begin memRdValid = 1; memRdData = DW'(rd_base + ctl_beats); end
          ctl_beats++;
        end
        ctl_ph = !ctl_ph;
      end else begin
        ctl_busy = 0;
      end
    end else if (memCmdValid) begin
      ctl_wait++;
      if (ctl_wait >= ctl_delay) begin
        memCmdReady = 1; ctl_accepted = 1; ctl_acc_we = memCmdWe; ctl_wait = 0;
      end
    end else begin
      ctl_wait = 0;
    end
    if (dispGnt && !hold_disp) dispReq = 0;
    if (lifeGnt) lifeReq = 0;
    if (pulse_rd) begin memRdValid = 1; memRdData = 32'h5A; pulse_rd = 0; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, q0, w0, dn0, ld0, lr0, dg0, lg0, req_cyc, s;
    rstN = 0;
    dispReq = 0; dispAddr = '0; lifeReq = 0; lifeWe = 0; lifeAddr = '0; lifeWrData = '0;
    memCmdReady = 0; memWrReady = 0; memRdValid = 0; memRdData = '0;
    @(negedge clk);
    chk("reset_cmd_valid", 64'(memCmdValid), 64'd0);
    chk("reset_proto", 64'(protoErr), 64'd0);
    chk("reset_gnt", 64'({dispGnt, lifeGnt, dispDone, lifeDone}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstN = 1;
    step();

    // 1: display read, controller accepts on the second ISSUE cycle
    ctl_delay = 2; ctl_toggle = 0; rd_base = 32'hA0;
    q0 = disp_q.size(); dn0 = disp_done_n; lr0 = life_rd_n; lg0 = life_gnt_n;
    dispReq = 1; dispAddr = 25'h000100; req_cyc = cyc;
    n = 0;
    while (disp_done_n == dn0 && n < 40) begin step(); n++; end
    step(); step();
    chk("t1_gnt_latency", 64'(disp_gnt_cyc - req_cyc), 64'd1);
    chk("t1_cmd_addr", 64'(last_addr), 64'h100);
    chk("t1_cmd_we", 64'(last_we), 64'd0);
    chk("t1_beats", 64'(disp_q.size() - q0), 64'd8);
    for (int i = 0; i < BL; i++)
      if (q0 + i < disp_q.size()) chk("t1_beat_data", 64'(disp_q[q0 + i]), 64'(32'hA0 + i));
    chk("t1_done", 64'(disp_done_n - dn0), 64'd1);
    chk("t1_life_quiet", 64'((life_rd_n - lr0) + (life_gnt_n - lg0)), 64'd0);

    // 2: life write, controller consumes every other cycle
    ctl_delay = 0; ctl_toggle = 1; wr_base = 32'hC0;
    w0 = wr_q.size(); ld0 = life_done_n;
    lifeReq = 1; lifeWe = 1; lifeAddr = 25'h1F0000;
    n = 0;
    while (life_done_n == ld0 && n < 60) begin step(); n++; end
    step(); step();
    lifeWe = 0; ctl_toggle = 0;
    chk("t2_acks", 64'(wr_q.size() - w0), 64'd8);
    for (int i = 0; i < BL; i++)
      if (w0 + i < wr_q.size()) chk("t2_wr_data", 64'(wr_q[w0 + i]), 64'(32'hC0 + i));
    chk("t2_cmd", 64'({last_we, last_addr}), 64'({1'b1, 25'h1F0000}));
    chk("t2_done_after_ack", 64'(life_done_cyc - last_ack_cyc), 64'd1);

    // 3: simultaneous requests, display first, life right after the idle gap
    ctl_delay = 1; rd_base = 32'h10;
    ld0 = life_done_n; lr0 = life_rd_n;
    dispReq = 1; dispAddr = 25'h200; lifeReq = 1; lifeWe = 0; lifeAddr = 25'h300;
    n = 0;
    while (life_done_n == ld0 && n < 80) begin step(); n++; end
    step(); step();
    chk("t3_disp_first", 64'(disp_gnt_cyc < life_gnt_cyc), 64'd1);
    chk("t3_life_gap", 64'(life_gnt_cyc - disp_done_cyc), 64'd2);
    chk("t3_life_beats", 64'(life_rd_n - lr0), 64'd8);
    chk("t3_last_addr", 64'(last_addr), 64'h300);

    // 6: display held continuously against a waiting life request
    ctl_delay = 0; rd_base = 32'h40;
    hold_disp = 1; dispReq = 1; dispAddr = 25'h400;
    lifeReq = 1; lifeWe = 0; lifeAddr = 25'h500;
    s = cyc; lg0 = life_gnt_n; dg0 = disp_gnt_n;
    n = 0;
    while (life_gnt_n == lg0 && n < 150) begin step(); n++; end
`ifdef ARB_AGING_EN
    chk("t6_life_granted", 64'(life_gnt_n - lg0), 64'd1);
    chk("t6_wait_bound", 64'((life_gnt_cyc - s >= MW + 1) && (life_gnt_cyc - s <= MW + BL + 5)), 64'd1);
`else
    chk("t6_life_starved", 64'(life_gnt_n - lg0), 64'd0);
    chk("t6_disp_served", 64'(disp_gnt_n - dg0 >= 5), 64'd1);
`endif
    hold_disp = 0; dispReq = 0; lifeReq = 0;
    repeat (30) step();

    // 4: stray read strobe while idle
    q0 = disp_q.size(); lr0 = life_rd_n;
    pulse_rd = 1;
    repeat (3) step();
    chk("t4_proto_set", 64'(protoErr), 64'd1);
    chk("t4_not_forwarded", 64'((disp_q.size() - q0) + (life_rd_n - lr0)), 64'd0);
    dn0 = disp_done_n;
    dispReq = 1; dispAddr = 25'h10;
    n = 0;
    while (disp_done_n == dn0 && n < 40) begin step(); n++; end
    step(); step();
    chk("t4_sticky", 64'(protoErr), 64'd1);

    // 5: reset in the middle of a read burst
    rd_base = 32'h70;
    q0 = disp_q.size(); dn0 = disp_done_n;
    dispReq = 1; dispAddr = 25'h600;
    n = 0;
    while (disp_q.size() - q0 < 3 && n < 40) begin step(); n++; end
    chk("t5_reached_beat3", 64'(disp_q.size() - q0), 64'd3);
    #2 rstN = 0;
    #1;
    chk("t5_outputs_zero", 64'(|{dispGnt, dispRdValid, dispRdData, dispDone, lifeGnt, lifeWrAck,
        lifeRdValid, lifeRdData, lifeDone, memCmdValid, memCmdWe, memCmdAddr, memWrData, protoErr}), 64'd0);
    chk("t5_proto_cleared", 64'(protoErr), 64'd0);
    ctl_busy = 0; ctl_accepted = 0; ctl_wait = 0; dispReq = 0;
    memRdValid = 0; memRdData = '0; memCmdReady = 0; memWrReady = 0;
    repeat (2) @(posedge clk);
    #1 rstN = 1;
    repeat (5) step();
    chk("t5_no_done", 64'(disp_done_n - dn0), 64'd0);
    q0 = disp_q.size();
    dispReq = 1; dispAddr = 25'h700;
    n = 0;
    while (disp_done_n == dn0 && n < 40) begin step(); n++; end
    step(); step();
    chk("t5_fresh_done", 64'(disp_done_n - dn0), 64'd1);
    chk("t5_fresh_beats", 64'(disp_q.size() - q0), 64'd8);
    if (disp_q.size() > q0) chk("t5_fresh_first", 64'(disp_q[q0]), 64'h70);
    chk("t5_fresh_addr", 64'(last_addr), 64'h700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
